// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t - sequencer states (IDLE, ACCESS, RESP)
//   PORT_MEM    - index of the pipeline MEM-stage requester
//   PORT_DBG    - index of the debug/DMA loader requester
//   WORD_SHIFT  - byte-address to word-index shift
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-requester arbiter.
// Ports:
//   req[1:0]   - request per port (bit index = port number)
//   last_grant - port that won the previous arbitration
//   fixed_prio - 1: port 0 wins every tie; 0: the port not granted last wins
//   grant[1:0] - one-hot grant, all-zero when nobody requests
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  // Grant selection: a lone requester always wins; ties use the priority rule.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant[PORT_MEM] = 1'b1;
      2'b10: grant[PORT_DBG] = 1'b1;
      2'b11: begin
        // last_grant == PORT_DBG means port 0 is the "other" port this time
        if (fixed_prio || (last_grant == PORT_DBG)) begin
          grant[PORT_MEM] = 1'b1;
        end else begin
          grant[PORT_DBG] = 1'b1;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-port data
// memory. One access at a time: IDLE arbitrates and latches the winner,
// ACCESS drives the memory strobes for one cycle, RESP returns ack/err/rdata
// to the granted port for one cycle. Misaligned or out-of-range requests skip
// ACCESS and are answered with err.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*        - request channel of port 0 (MEM) and 1 (DBG)
//   ack*/err*/rdata*             - one-cycle response of each port
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata - memory interface
//   busy                         - high while in ACCESS or RESP
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  arb_state_t  state_r;
  arb_state_t  state_next_s;
  logic        last_grant_r;
  logic        port_r;
  logic        we_r;
  logic [1:0]  grant_s;
  logic        win_port_s;
  logic        win_we_s;
  logic        win_legal_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;

  // Word-aligned and inside the memory; anything else never reaches mem_addr.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[WORD_SHIFT-1:0] == {WORD_SHIFT{1'b0}}) && (a < ADDR_LIMIT);
  endfunction

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant_r),
    .fixed_prio (FIXED_PRIO),
    .grant      (grant_s)
  );

  // Winner mux: fields of the granted port and their legality.
  always_comb begin
    win_port_s  = PORT_MEM;
    win_we_s    = we0;
    win_addr_s  = addr0;
    win_wdata_s = wdata0;
    if (grant_s[PORT_DBG]) begin
      win_port_s  = PORT_DBG;
      win_we_s    = we1;
      win_addr_s  = addr1;
      win_wdata_s = wdata1;
    end else begin
      win_port_s  = PORT_MEM;
      win_we_s    = we0;
      win_addr_s  = addr0;
      win_wdata_s = wdata0;
    end
    win_legal_s = addr_legal(win_addr_s);
  end

  // Next-state logic of the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_next_s = win_legal_s ? ACCESS : RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, memory strobes and per-port responses (all registered).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= PORT_DBG;
      port_r       <= PORT_MEM;
      we_r         <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= 32'd0;
      rdata1       <= 32'd0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s != 2'b00) begin
            last_grant_r <= win_port_s;
            port_r       <= win_port_s;
            we_r         <= win_we_s;
            if (win_legal_s) begin
              mem_addr  <= win_addr_s;
              mem_wdata <= win_wdata_s;
              mem_write <= win_we_s;
              mem_read  <= ~win_we_s;
            end else begin
              // Rejected: answer next cycle, memory interface untouched.
              ack0 <= (win_port_s == PORT_MEM);
              err0 <= (win_port_s == PORT_MEM);
              ack1 <= (win_port_s == PORT_DBG);
              err1 <= (win_port_s == PORT_DBG);
            end
          end
        end
        ACCESS: begin
          // The memory commits a write / presents read data at this edge.
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= (port_r == PORT_MEM);
          ack1      <= (port_r == PORT_DBG);
          err0      <= 1'b0;
          err1      <= 1'b0;
          rdata0    <= ((port_r == PORT_MEM) && !we_r) ? mem_rdata : 32'd0;
          rdata1    <= ((port_r == PORT_DBG) && !we_r) ? mem_rdata : 32'd0;
        end
        RESP: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          err0   <= 1'b0;
          err1   <= 1'b0;
          rdata0 <= 32'd0;
          rdata1 <= 32'd0;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          err0      <= 1'b0;
          err1      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Instance 0 uses
// round-robin, instance 1 fixed priority; each has its own behavioural data
// memory. A transaction-level reference model predicts, per clock edge, which
// port is served, when the strobe and ack appear and what the response holds.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req0 [2], req1 [2], we0 [2], we1 [2];
  logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
  logic        ack0 [2], ack1 [2], err0 [2], err1 [2];
  logic [31:0] rdata0 [2], rdata1 [2];
  logic        mem_read [2], mem_write [2], busy [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [31:0] mem_arr [64];
    logic [31:0] rd_q;

    dmem_arbiter #(.MEM_WORDS(64), .FIXED_PRIO(d == 1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0[d]), .req1(req1[d]), .we0(we0[d]), .we1(we1[d]),
      .addr0(addr0[d]), .addr1(addr1[d]), .wdata0(wdata0[d]), .wdata1(wdata1[d]),
      .ack0(ack0[d]), .ack1(ack1[d]), .err0(err0[d]), .err1(err1[d]),
      .rdata0(rdata0[d]), .rdata1(rdata1[d]),
      .mem_read(mem_read[d]), .mem_write(mem_write[d]),
      .mem_addr(mem_addr[d]), .mem_wdata(mem_wdata[d]), .mem_rdata(mem_rdata[d]),
      .busy(busy[d])
    );

    // Single-port memory: write on posedge, read data valid after negedge.
    initial for (int i = 0; i < 64; i++) mem_arr[i] <= 32'd0;
    always @(posedge clk) if (mem_write[d]) mem_arr[mem_addr[d][7:2]] <= mem_wdata[d];
    always @(negedge clk) if (mem_read[d]) rd_q <= mem_arr[mem_addr[d][7:2]];
    assign mem_rdata[d] = rd_q;
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, per instance.
  int          ecnt [2];
  int          avail [2];
  int          lastg [2];
  int          resp_at [2], strobe_at [2], rport [2];
  logic        rerr [2], swe [2], pend_w [2];
  logic [31:0] rdat [2], saddr [2], swdata [2];
  logic [31:0] mref [2][64];
  int          wcnt [2], rcnt [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    avail[d] = 0; lastg[d] = 1; resp_at[d] = -10; strobe_at[d] = -10;
    rport[d] = 0; rerr[d] = 1'b0; rdat[d] = 32'd0; pend_w[d] = 1'b0;
    swe[d] = 1'b0; saddr[d] = 32'd0; swdata[d] = 32'd0;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge(input int d);
    int e, p;
    logic w, legal;
    logic [31:0] a, wd;
    e = ecnt[d];
    if (pend_w[d] && (e == strobe_at[d] + 1)) begin
      mref[d][saddr[d][7:2]] = swdata[d];
      pend_w[d] = 1'b0;
    end
    if ((e >= avail[d]) && (req0[d] || req1[d])) begin
      if (req0[d] && req1[d]) p = (d == 1) ? 0 : 1 - lastg[d];
      else p = req0[d] ? 0 : 1;
      lastg[d] = p;
      rport[d] = p;
      w  = (p == 1) ? we1[d] : we0[d];
      a  = (p == 1) ? addr1[d] : addr0[d];
      wd = (p == 1) ? wdata1[d] : wdata0[d];
      legal = ((a % 4) == 0) && (a < 32'd256);
      if (legal) begin
        strobe_at[d] = e; resp_at[d] = e + 1; avail[d] = e + 3;
        rerr[d] = 1'b0; swe[d] = w; saddr[d] = a; swdata[d] = wd; pend_w[d] = w;
        rdat[d] = w ? 32'd0 : mref[d][a[7:2]];
      end else begin
        resp_at[d] = e; avail[d] = e + 2; rerr[d] = 1'b1; rdat[d] = 32'd0;
      end
    end
  endtask

  task automatic check_outputs(input int d);
    int e;
    logic a0, a1, stb;
    e   = ecnt[d];
    a0  = (resp_at[d] == e) && (rport[d] == 0);
    a1  = (resp_at[d] == e) && (rport[d] == 1);
    stb = (strobe_at[d] == e);
    check_eq($sformatf("d%0d e%0d ack0", d, e), 32'(ack0[d]), 32'(a0));
    check_eq($sformatf("d%0d e%0d ack1", d, e), 32'(ack1[d]), 32'(a1));
    check_eq($sformatf("d%0d e%0d err0", d, e), 32'(err0[d]), 32'(a0 && rerr[d]));
    check_eq($sformatf("d%0d e%0d err1", d, e), 32'(err1[d]), 32'(a1 && rerr[d]));
    check_eq($sformatf("d%0d e%0d rdata0", d, e), rdata0[d], a0 ? rdat[d] : 32'd0);
    check_eq($sformatf("d%0d e%0d rdata1", d, e), rdata1[d], a1 ? rdat[d] : 32'd0);
    check_eq($sformatf("d%0d e%0d mem_write", d, e), 32'(mem_write[d]), 32'(stb && swe[d]));
    check_eq($sformatf("d%0d e%0d mem_read", d, e), 32'(mem_read[d]), 32'(stb && !swe[d]));
    check_eq($sformatf("d%0d e%0d busy", d, e), 32'(busy[d]), 32'(e < avail[d] - 1));
    if (stb) begin
      check_eq($sformatf("d%0d e%0d mem_addr", d, e), mem_addr[d], saddr[d]);
      check_eq($sformatf("d%0d e%0d mem_wdata", d, e), mem_wdata[d], swdata[d]);
    end
    if (mem_write[d]) wcnt[d]++;
    if (mem_read[d]) rcnt[d]++;
  endtask

  task automatic tick(input int d);
    @(posedge clk);
    ecnt[d]++;
    model_edge(d);
    @(negedge clk);
    check_outputs(d);
  endtask

  task automatic set_port(input int d, input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
    end else begin
      req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      set_port(d, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(d, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask

  // Tick until port p acks; 'at' is the edge after which ack was seen, -1 on timeout.
  task automatic wait_ack(input int d, input int p, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(d);
      if ((p == 0) ? ack0[d] : ack1[d]) begin
        at = ecnt[d];
        break;
      end
    end
    check_eq($sformatf("d%0d p%0d ack_seen", d, p), 32'(at >= 0), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(7, 0);
    a = {24'd0, 6'($urandom_range(63, 0)), 2'b00};
    if (k == 0) a[1:0] = 2'($urandom_range(3, 1));
    else if (k == 1) a = 32'h100 + 32'($urandom_range(1023, 0)) * 32'd4;
    else if (k == 2) a = $urandom();
    return a;
  endfunction

  task automatic rand_drive(input int d, input int p);
    logic cur, acked;
    cur   = (p == 0) ? req0[d] : req1[d];
    acked = (p == 0) ? ack0[d] : ack1[d];
    if (cur && acked) begin
      if ($urandom_range(1, 0) == 0) set_port(d, p, 1'b0, 1'b0, 32'd0, 32'd0);
      else set_port(d, p, 1'b1, 1'($urandom_range(1, 0)), rand_addr(), $urandom());
    end else if (!cur && ($urandom_range(2, 0) == 0)) begin
      set_port(d, p, 1'b1, 1'($urandom_range(1, 0)), rand_addr(), $urandom());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at, t0, n, s0;
    int ord [4];
    int acy [4];
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0; wcnt[d] = 0; rcnt[d] = 0;
      for (int i = 0; i < 64; i++) mref[d][i] = 32'd0;
    end
    do_reset();

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d rst ack0", d), 32'(ack0[d]), 32'd0);
      check_eq($sformatf("d%0d rst ack1", d), 32'(ack1[d]), 32'd0);
      check_eq($sformatf("d%0d rst strobes", d), 32'({mem_read[d], mem_write[d]}), 32'd0);
      check_eq($sformatf("d%0d rst mem_addr", d), mem_addr[d], 32'd0);
      check_eq($sformatf("d%0d rst mem_wdata", d), mem_wdata[d], 32'd0);
      check_eq($sformatf("d%0d rst rdata0", d), rdata0[d], 32'd0);
      check_eq($sformatf("d%0d rst busy", d), 32'(busy[d]), 32'd0);
    end

    // Port 0 write then read back.
    set_port(0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    t0 = ecnt[0] + 1; s0 = wcnt[0];
    wait_ack(0, 0, at);
    check_eq("wr latency", 32'(at - t0), 32'd1);
    check_eq("wr strobe cycles", 32'(wcnt[0] - s0), 32'd1);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);
    set_port(0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
    t0 = ecnt[0] + 1;
    wait_ack(0, 0, at);
    check_eq("rd latency", 32'(at - t0), 32'd1);
    check_eq("rd rdata0", rdata0[0], 32'hDEADBEEF);
    check_eq("rd err0", 32'(err0[0]), 32'd0);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);

    // Round-robin with both requests held, right after reset.
    do_reset();
    set_port(0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
    set_port(0, 1, 1'b1, 1'b0, 32'h10, 32'd0);
    n = 0;
    for (int k = 0; k < 4; k++) begin ord[k] = 9; acy[k] = 0; end
    for (int i = 0; (i < 30) && (n < 4); i++) begin
      tick(0);
      if (ack0[0] || ack1[0]) begin
        ord[n] = ack1[0] ? 1 : 0; acy[n] = ecnt[0]; n++;
      end
    end
    check_eq("rr ack count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) check_eq($sformatf("rr order %0d", k), 32'(ord[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) check_eq($sformatf("rr gap %0d", k), 32'(acy[k] - acy[k-1]), 32'd3);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0); tick(0);

    // Fixed priority: port 0 starves port 1 while it keeps requesting.
    set_port(1, 0, 1'b1, 1'b0, 32'h04, 32'd0);
    set_port(1, 1, 1'b1, 1'b0, 32'h08, 32'd0);
    n = 0; s0 = 0;
    for (int i = 0; (i < 30) && (n < 4); i++) begin
      tick(1);
      if (ack0[1]) n++;
      if (ack1[1]) s0++;
    end
    check_eq("fp port0 acks", 32'(n), 32'd4);
    check_eq("fp port1 acks", 32'(s0), 32'd0);
    tick(1);
    set_port(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    t0 = ecnt[1];
    wait_ack(1, 1, at);
    check_eq("fp port1 after drop", 32'(at - t0), 32'd2);
    set_port(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1);

    // Illegal addresses: misaligned, then out of range.
    s0 = wcnt[0] + rcnt[0];
    set_port(0, 0, 1'b1, 1'b0, 32'h13, 32'd0);
    t0 = ecnt[0] + 1;
    wait_ack(0, 0, at);
    check_eq("misaligned latency", 32'(at - t0), 32'd0);
    check_eq("misaligned err0", 32'(err0[0]), 32'd1);
    check_eq("misaligned rdata0", rdata0[0], 32'd0);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);
    set_port(0, 0, 1'b1, 1'b0, 32'h100, 32'd0);
    t0 = ecnt[0] + 1;
    wait_ack(0, 0, at);
    check_eq("range latency", 32'(at - t0), 32'd0);
    check_eq("range err0", 32'(err0[0]), 32'd1);
    check_eq("range rdata0", rdata0[0], 32'd0);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);
    check_eq("illegal strobes", 32'(wcnt[0] + rcnt[0] - s0), 32'd0);

    // Reset during the ACCESS cycle of a write.
    set_port(0, 0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    tick(0);
    check_eq("midrst write strobe", 32'(mem_write[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst mem_write", 32'(mem_write[0]), 32'd0);
    check_eq("midrst mem_addr", mem_addr[0], 32'd0);
    check_eq("midrst mem_wdata", mem_wdata[0], 32'd0);
    check_eq("midrst busy", 32'(busy[0]), 32'd0);
    check_eq("midrst ack0", 32'(ack0[0]), 32'd0);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset(0);
    model_reset(1);
    set_port(0, 0, 1'b1, 1'b0, 32'h20, 32'd0);
    wait_ack(0, 0, at);
    check_eq("midrst readback", rdata0[0], 32'd0);
    set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);

    // Port 1 changes its address while the read is in ACCESS.
    set_port(0, 1, 1'b1, 1'b1, 32'h08, 32'hCAFE0001);
    wait_ack(0, 1, at);
    set_port(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);
    set_port(0, 1, 1'b1, 1'b0, 32'h08, 32'd0);
    tick(0);
    set_port(0, 1, 1'b1, 1'b0, 32'h0C, 32'h55555555);
    wait_ack(0, 1, at);
    check_eq("field change rdata1", rdata1[0], 32'hCAFE0001);
    set_port(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(0);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 400; i++) begin
        tick(d);
        rand_drive(d, 0);
        rand_drive(d, 1);
      end
      set_port(d, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(d, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (4) tick(d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
